bram_sweeper: RTL and testbench
===============================

# bram_sweeper

Initiator that drives one port of the dual-port BRAM controller. It sweeps every interior cell of a 2-D cell array stored in BRAM and issues one NEIG-mode read per cell. Each neighborhood word goes to the compute stage over a valid/ready handshake. The block then accepts that stage's result and writes it back as a BYTE-mode write into a destination array with the same geometry. It sits between the evolution compute pipeline and `bramctl` port 0 or port 1, and is the requester side of the port protocol.

## Interface
- AW, 40, address width (matches `MemAddr*`)
- DW, 40, data width (matches `MemDataIn*`/`MemDataOut*`)
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- base_addr  in  AW  byte address of source cell (0,0)
- dest_addr  in  AW  byte address of destination cell (0,0)
- arraywidth  in  16  row pitch in bytes
- rows  in  16  array height in cells
- cols  in  16  array width in cells
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of sweep
- MemAddr  out  AW  to bramctl `MemAddr`
- MemDataIn  out  DW  to bramctl `MemDataIn`, write data
- MemDataOut  in  DW  from bramctl `MemDataOut`, read data
- mode  out  2  BYTE=2'b00, HALF=2'b01, WORD=2'b10, NEIG=2'b11
- RW  out  1  1=read, 0=write
- nb_valid  out  1  neighborhood word available
- nb_data  out  DW  neighborhood word
- nb_ready  in  1  compute stage accepts nb_data
- res_valid  in  1  result byte available
- res_data  in  8  result byte
- res_ready  out  1  sweeper accepts res_data

## Operation
- The sweeper captures base_addr, dest_addr, arraywidth, rows, and cols on an accepted start. Input changes during a sweep have no effect.
- Cells visited: r = 1..rows-2 (outer loop), c = 1..cols-2 (inner loop), row-major.
- Source address: base_addr + r*arraywidth + c. Destination address: dest_addr + r*arraywidth + c.
- Both addresses are kept incrementally. Moving to the next column adds 1. Moving to the next row adds arraywidth to the row start, then adds 1.
- Address arithmetic is AW-bit and wraps modulo 2^AW. arraywidth is zero-extended.
- If rows<3 or cols<3, the sweep is degenerate: the block goes START->DONE with no bus access and no handshakes.
- FSM states and transitions:
  - IDLE: on start, go to RD, or to DONE if degenerate.
  - RD: drive MemAddr=src, mode=NEIG, RW=1 for exactly one cycle, then go to RWAIT.
  - RWAIT: capture MemDataOut into the nb register, then go to OFFER.
  - OFFER: nb_valid=1. When nb_ready=1, go to WAITRES.
  - WAITRES: res_ready=1. When res_valid=1, capture res_data and go to WR.
  - WR: drive MemAddr=dst, mode=BYTE, RW=0, MemDataIn={32'b0,res} for exactly one cycle. Then go to RD for the next cell, or to DONE after the last cell.
  - DONE: done=1 for one cycle, then go to IDLE.
- Idle bus value (every state except RD and WR): MemAddr=0, MemDataIn=0, mode=WORD, RW=1. This is a harmless read, and the controller never sees a spurious write.
- nb_data is held stable from entry to OFFER until the handshake completes.
- start asserted in the DONE cycle is ignored.

## Timing
- Reset values: busy=0, done=0, nb_valid=0, nb_data=0, res_ready=0, MemAddr=0, MemDataIn=0, mode=WORD, RW=1. The FSM is in IDLE.
- Every output is a register, with no combinational input-to-output path.
- Read latency: data for the RD-cycle request is sampled on the RWAIT edge, one clk after the RD cycle.
- Minimum cost per cell is 5 cycles: RD, RWAIT, OFFER, WAITRES, WR, with nb_ready and res_valid both held high.
- A start accepted at edge k makes busy=1 after edge k, and RD is driven in the cycle after edge k.
- For a degenerate sweep, done pulses in the cycle after start.
- Reset asserted mid-sweep forces all outputs to their reset values immediately, even during WR. The pending write is abandoned, and no partial state survives.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> all outputs at reset values; busy=0 after release.
- Single cell: base=80, dest=200, arraywidth=6, rows=3, cols=3, memory model returns 40'hdeadbeef23 at 87, compute stage answers 8'hA5 -> one NEIG read at 87; nb_data=40'hdeadbeef23; BYTE write at 207 of 40'h00000000A5; done one cycle after WR; exactly 5 busy cycles before DONE.
- Multi-row: base=0, dest=1000, arraywidth=8, rows=4, cols=5 -> reads in order 9,10,11,17,18,19; writes in order 1009,1010,1011,1017,1018,1019; read and write accesses interleave one-for-one.
- Backpressure: hold nb_ready=0 for 5 cycles, then res_valid=0 for 4 cycles -> nb_valid and nb_data stable throughout; bus stays at the idle value; write occurs only after res_valid.
- Degenerate: rows=2, cols=10, and separately cols=0 -> done pulse in the cycle after start; RW stays 1 and nb_valid stays 0.
- Reset mid-op: assert rst_n=0 during WAITRES of the second cell -> no write at that cell's destination; a fresh start afterwards repeats the full sweep correctly; start pulses while busy are ignored.

Source files
------------

// File: rtl/bram_sweeper.sv
// Sweeps the interior cells of a 2-D array held in BRAM. For each cell it issues a NEIG read,
// offers the neighborhood to the compute stage, and writes the returned byte to the destination array.
module bram_sweeper #(
    parameter int AW = 40,
    parameter int DW = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] dest_addr,
    input  logic [15:0]   arraywidth,
    input  logic [15:0]   rows,
    input  logic [15:0]   cols,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemDataIn,
    input  logic [DW-1:0] MemDataOut,
    output logic [1:0]    mode,
    output logic          RW,
    output logic          nb_valid,
    output logic [DW-1:0] nb_data,
    input  logic          nb_ready,
    input  logic          res_valid,
    input  logic [7:0]    res_data,
    output logic          res_ready
);

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_NEIG = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        OFFER,
        WAITRES,
        WR,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] pitch;
    logic [AW-1:0] src_row;
    logic [AW-1:0] dst_row;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [15:0]   row_idx;
    logic [15:0]   col_idx;
    logic [15:0]   row_last;
    logic [15:0]   col_last;

    logic [AW-1:0] aw_ext;
    logic [AW-1:0] row1_src;
    logic [AW-1:0] row1_dst;
    logic [AW-1:0] next_src_row;
    logic [AW-1:0] next_dst_row;
    logic          degenerate;

    // Row starts are tracked separately so a row step is one add of the pitch, never a multiply.
    assign aw_ext       = {{(AW-16){1'b0}}, arraywidth};
    assign row1_src     = base_addr + aw_ext;
    assign row1_dst     = dest_addr + aw_ext;
    assign next_src_row = src_row + pitch;
    assign next_dst_row = dst_row + pitch;
    assign degenerate   = (rows < 16'd3) || (cols < 16'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            MemAddr   <= '0;
            MemDataIn <= '0;
            mode      <= MODE_WORD;
            RW        <= 1'b1;
            nb_valid  <= 1'b0;
            nb_data   <= '0;
            res_ready <= 1'b0;
            pitch     <= '0;
            src_row   <= '0;
            dst_row   <= '0;
            src       <= '0;
            dst       <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            row_last  <= '0;
            col_last  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        pitch    <= aw_ext;
                        row_last <= rows - 16'd2;
                        col_last <= cols - 16'd2;
                        row_idx  <= 16'd1;
                        col_idx  <= 16'd1;
                        src_row  <= row1_src;
                        dst_row  <= row1_dst;
                        src      <= row1_src + AW'(1);
                        dst      <= row1_dst + AW'(1);
                        if (degenerate) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RD;
                            MemAddr <= row1_src + AW'(1);
                            mode    <= MODE_NEIG;
                            RW      <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state   <= RWAIT;
                    MemAddr <= '0;
                    mode    <= MODE_WORD;
                end
                RWAIT: begin
                    nb_data  <= MemDataOut;
                    nb_valid <= 1'b1;
                    state    <= OFFER;
                end
                OFFER: begin
                    if (nb_ready) begin
                        nb_valid  <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= WAITRES;
                    end
                end
                WAITRES: begin
                    if (res_valid) begin
                        res_ready <= 1'b0;
                        MemAddr   <= dst;
                        MemDataIn <= {{(DW-8){1'b0}}, res_data};
                        mode      <= MODE_BYTE;
                        RW        <= 1'b0;
                        state     <= WR;
                    end
                end
                // The write lasts one cycle; the next read address is registered on the same edge.
                WR: begin
                    MemAddr   <= '0;
                    MemDataIn <= '0;
                    mode      <= MODE_WORD;
                    RW        <= 1'b1;
                    if (col_idx == col_last) begin
                        if (row_idx == row_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            row_idx <= row_idx + 16'd1;
                            col_idx <= 16'd1;
                            src_row <= next_src_row;
                            dst_row <= next_dst_row;
                            src     <= next_src_row + AW'(1);
                            dst     <= next_dst_row + AW'(1);
                            MemAddr <= next_src_row + AW'(1);
                            mode    <= MODE_NEIG;
                            state   <= RD;
                        end
                    end else begin
                        col_idx <= col_idx + 16'd1;
                        src     <= src + AW'(1);
                        dst     <= dst + AW'(1);
                        MemAddr <= src + AW'(1);
                        mode    <= MODE_NEIG;
                        state   <= RD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_sweeper.sv
// Scoreboard bench for bram_sweeper: a BRAM model, a compute-stage model and bus/handshake monitors.
module tb_bram_sweeper;

    localparam int AW = 40;
    localparam int DW = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] dest_addr = '0;
    logic [15:0]   arraywidth = '0;
    logic [15:0]   rows = '0;
    logic [15:0]   cols = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemDataIn;
    logic [DW-1:0] mem_out = '0;
    logic [1:0]    mode;
    logic          RW;
    logic          nb_valid;
    logic [DW-1:0] nb_data;
    logic          nb_ready = 1'b1;
    logic          res_valid = 1'b1;
    logic [7:0]    res_data = '0;
    logic          res_ready;

    int checks = 0;
    int errors = 0;
    int outstanding = 0;
    int wr_seen = 0;
    int nb_hs = 0;

    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] nb_q[$];
    logic [7:0]    res_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];

    bram_sweeper #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .dest_addr(dest_addr),
        .arraywidth(arraywidth), .rows(rows), .cols(cols),
        .busy(busy), .done(done),
        .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemDataOut(mem_out),
        .mode(mode), .RW(RW),
        .nb_valid(nb_valid), .nb_data(nb_data), .nb_ready(nb_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 40'd87) return 40'hdeadbeef23;
        return {a[7:0], a[31:0]} ^ 40'h5a5a5a5a5a;
    endfunction

    function automatic logic [7:0] res_fn(input logic [AW-1:0] a);
        if (a == 40'd87) return 8'hA5;
        return a[7:0] ^ 8'h3c;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Registered read with one cycle of latency, like the controller port.
    always @(posedge clk) mem_out <= mem_fn(MemAddr);

    // Bus monitor and compute-stage model; inputs from here change only at negedge.
    always @(negedge clk) begin
        if (RW == 1'b0) begin
            checkOutput("wr_mode", 64'(mode), 64'(2'b00));
            checkOutput("interleave_wr", 64'(outstanding), 64'd1);
            if (wr_addr_q.size() == 0) begin
                checkOutput("spurious_wr", 64'd1, 64'd0);
            end else begin
                checkOutput("wr_addr", 64'(MemAddr), 64'(wr_addr_q.pop_front()));
                checkOutput("wr_data", 64'(MemDataIn), 64'(wr_data_q.pop_front()));
            end
            outstanding = 0;
            wr_seen++;
        end else if (mode == 2'b11) begin
            checkOutput("interleave_rd", 64'(outstanding), 64'd0);
            checkOutput("rd_din", 64'(MemDataIn), 64'd0);
            if (rd_q.size() == 0) begin
                checkOutput("spurious_rd", 64'd1, 64'd0);
            end else begin
                checkOutput("rd_addr", 64'(MemAddr), 64'(rd_q.pop_front()));
            end
            outstanding = 1;
        end else begin
            checkOutput("idle_addr", 64'(MemAddr), 64'd0);
            checkOutput("idle_din", 64'(MemDataIn), 64'd0);
            checkOutput("idle_mode", 64'(mode), 64'(2'b10));
        end
        if (nb_valid && nb_ready) begin
            nb_hs++;
            if (nb_q.size() == 0) begin
                checkOutput("spurious_nb", 64'd1, 64'd0);
            end else begin
                checkOutput("nb_data", 64'(nb_data), 64'(nb_q.pop_front()));
                res_data = res_q.pop_front();
            end
        end
    end

    task automatic checkResetValues();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_nb_valid", 64'(nb_valid), 64'd0);
        checkOutput("rst_nb_data", 64'(nb_data), 64'd0);
        checkOutput("rst_res_ready", 64'(res_ready), 64'd0);
        checkOutput("rst_addr", 64'(MemAddr), 64'd0);
        checkOutput("rst_din", 64'(MemDataIn), 64'd0);
        checkOutput("rst_mode", 64'(mode), 64'(2'b10));
        checkOutput("rst_rw", 64'(RW), 64'd1);
    endtask

    task automatic pushSweep(input logic [AW-1:0] b, input logic [AW-1:0] d,
                             input logic [15:0] w, input logic [15:0] nr, input logic [15:0] nc);
        logic [AW-1:0] a;
        logic [AW-1:0] da;
        for (int r = 1; r <= int'(nr) - 2; r++) begin
            for (int c = 1; c <= int'(nc) - 2; c++) begin
                a  = b + AW'(r) * {24'b0, w} + AW'(c);
                da = d + AW'(r) * {24'b0, w} + AW'(c);
                rd_q.push_back(a);
                nb_q.push_back(mem_fn(a));
                res_q.push_back(res_fn(a));
                wr_addr_q.push_back(da);
                wr_data_q.push_back({32'b0, res_fn(a)});
            end
        end
    endtask

    task automatic pulseStart(input logic [AW-1:0] b, input logic [AW-1:0] d,
                              input logic [15:0] w, input logic [15:0] nr, input logic [15:0] nc);
        @(negedge clk);
        base_addr  = b;
        dest_addr  = d;
        arraywidth = w;
        rows       = nr;
        cols       = nc;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(done), 64'd1);
    endtask

    // Full sweep with free-flowing handshakes; optionally pokes start and inputs mid-sweep.
    task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] d,
                                 input logic [15:0] w, input logic [15:0] nr, input logic [15:0] nc,
                                 input int exp_busy, input bit poke);
        int n = 0;
        int busy_cnt = 0;
        logic prev_rw = 1'b1;
        pushSweep(b, d, w, nr, nc);
        pulseStart(b, d, w, nr, nc);
        while (!done && n < 2000) begin
            if (busy) busy_cnt++;
            prev_rw = RW;
            if (poke && n == 7) begin
                start     = 1'b1;
                base_addr = 40'h123;
                rows      = 16'd9;
                cols      = 16'd9;
            end
            if (poke && n == 8) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checkOutput("done_seen", 64'(done), 64'd1);
        checkOutput("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        if (exp_busy == 0) checkOutput("done_latency", 64'(n), 64'd0);
        else checkOutput("wr_before_done", 64'(prev_rw), 64'd0);
        checkOutput("busy_in_done", 64'(busy), 64'd1);
        checkOutput("nb_idle_done", 64'(nb_valid), 64'd0);
        checkOutput("rd_left", 64'(rd_q.size()), 64'd0);
        checkOutput("wr_left", 64'(wr_addr_q.size()), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_pulse", 64'(done), 64'd0);
        checkOutput("idle_after", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("start_in_done_ign", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] held;
        int i;
        repeat (3) @(negedge clk);
        checkResetValues();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_rst", 64'(busy), 64'd0);

        $display("[TB] single cell");
        applyStimulus(40'd80, 40'd200, 16'd6, 16'd3, 16'd3, 5, 1'b0);

        $display("[TB] multi-row");
        applyStimulus(40'd0, 40'd1000, 16'd8, 16'd4, 16'd5, 30, 1'b0);

        $display("[TB] backpressure");
        @(posedge clk);
        #1;
        nb_ready  = 1'b0;
        res_valid = 1'b0;
        pushSweep(40'd300, 40'd500, 16'd10, 16'd3, 16'd3);
        pulseStart(40'd300, 40'd500, 16'd10, 16'd3, 16'd3);
        i = 0;
        while (!nb_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        checkOutput("bp_nb_valid_up", 64'(nb_valid), 64'd1);
        held = nb_data;
        checkOutput("bp_nb_first", 64'(held), 64'(mem_fn(40'd311)));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_nb_valid", 64'(nb_valid), 64'd1);
            checkOutput("bp_nb_stable", 64'(nb_data), 64'(held));
            checkOutput("bp_res_ready_lo", 64'(res_ready), 64'd0);
        end
        @(posedge clk);
        #1 nb_ready = 1'b1;
        i = 0;
        while (!res_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_res_ready", 64'(res_ready), 64'd1);
            checkOutput("bp_no_wr", 64'(RW), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_valid = 1'b1;
        waitDone("bp_done");
        checkOutput("bp_wr_left", 64'(wr_addr_q.size()), 64'd0);
        @(negedge clk);

        $display("[TB] degenerate");
        applyStimulus(40'd0, 40'd0, 16'd8, 16'd2, 16'd10, 0, 1'b0);
        applyStimulus(40'd0, 40'd0, 16'd8, 16'd5, 16'd0, 0, 1'b0);

        $display("[TB] reset mid-op");
        nb_hs   = 0;
        wr_seen = 0;
        pushSweep(40'd0, 40'd1000, 16'd8, 16'd4, 16'd5);
        pulseStart(40'd0, 40'd1000, 16'd8, 16'd4, 16'd5);
        i = 0;
        while (!(res_ready && nb_hs == 2) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        checkOutput("mid_reached", 64'(res_ready && nb_hs == 2), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues();
        @(negedge clk);
        checkOutput("mid_writes", 64'(wr_seen), 64'd1);
        rd_q.delete();
        nb_q.delete();
        res_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        outstanding = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(40'd0, 40'd1000, 16'd8, 16'd4, 16'd5, 30, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
